// File: rtl/botoes_condicionador.sv
// Push-button conditioning: 2-flop synchroniser, press/release debounce and one-hot enforcement.
// Optional macro BOTOES_PRIORIDADE_EN resolves chords to the lowest-index button instead of rejecting them.
module botoes_condicionador #(
    parameter int N_BOTOES        = 7,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int CNT_W           = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [N_BOTOES-1:0] botoes_raw,
    output logic [N_BOTOES-1:0] botoes,
    output logic                pressionado,
    output logic                erro_multiplo,
    output logic [2:0]          db_estado
);

    localparam logic [2:0] OCIOSO       = 3'd0;
    localparam logic [2:0] CONFIRMA     = 3'd1;
    localparam logic [2:0] PRESSIONADO  = 3'd2;
    localparam logic [2:0] SOLTA        = 3'd3;
    localparam logic [2:0] ESPERA_SOLTA = 3'd4;

    localparam logic [CNT_W-1:0]    CNT_ULTIMO = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_UM     = CNT_W'(1);
    localparam logic [N_BOTOES-1:0] VEC_UM     = N_BOTOES'(1);

    logic [N_BOTOES-1:0] sync_1;
    logic [N_BOTOES-1:0] sync_2;

    logic [2:0]          estado;
    logic [2:0]          estado_prox;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_prox;
    logic [N_BOTOES-1:0] candidato;
    logic [N_BOTOES-1:0] candidato_prox;
    logic                erro_prox;
    logic [N_BOTOES-1:0] botoes_prox;

    logic [N_BOTOES-1:0] amostra;
    logic                amostra_zero;
    logic                amostra_multi;

    // Raw levels are asynchronous to the game clock; only sync_2 is ever used downstream.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= botoes_raw;
            sync_2 <= sync_1;
        end
    end

`ifdef BOTOES_PRIORIDADE_EN
    // Isolate the lowest set bit so a chord becomes an ordinary single press.
    always_comb begin
        amostra       = sync_2 & (~sync_2 + VEC_UM);
        amostra_zero  = (sync_2 == '0);
        amostra_multi = 1'b0;
    end
`else
    always_comb begin
        amostra       = sync_2;
        amostra_zero  = (sync_2 == '0);
        amostra_multi = !amostra_zero && ((sync_2 & (sync_2 - VEC_UM)) != '0);
    end
`endif

    always_comb begin
        estado_prox    = estado;
        cnt_prox       = cnt;
        candidato_prox = candidato;
        erro_prox      = 1'b0;

        if (!enable) begin
            estado_prox    = OCIOSO;
            cnt_prox       = '0;
            candidato_prox = '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    cnt_prox = '0;
                    if (amostra_multi) begin
                        erro_prox   = 1'b1;
                        estado_prox = ESPERA_SOLTA;
                    end else if (!amostra_zero) begin
                        candidato_prox = amostra;
                        estado_prox    = CONFIRMA;
                    end
                end

                // Any change at all, even to another one-hot code, aborts the press.
                CONFIRMA: begin
                    if (amostra != candidato) begin
                        estado_prox = OCIOSO;
                        cnt_prox    = '0;
                    end else if (cnt == CNT_ULTIMO) begin
                        estado_prox = PRESSIONADO;
                        cnt_prox    = '0;
                    end else begin
                        cnt_prox = cnt + CNT_UM;
                    end
                end

                PRESSIONADO: begin
                    cnt_prox = '0;
                    if (amostra_zero) begin
                        estado_prox = SOLTA;
                    end else if (amostra != candidato) begin
`ifdef BOTOES_PRIORIDADE_EN
                        estado_prox = OCIOSO;
`else
                        erro_prox   = 1'b1;
                        estado_prox = ESPERA_SOLTA;
`endif
                    end
                end

                // Output stays asserted here so a release bounce is invisible downstream.
                SOLTA: begin
                    if (amostra == candidato) begin
                        estado_prox = PRESSIONADO;
                        cnt_prox    = '0;
                    end else if (amostra_zero) begin
                        if (cnt == CNT_ULTIMO) begin
                            estado_prox = OCIOSO;
                            cnt_prox    = '0;
                        end else begin
                            cnt_prox = cnt + CNT_UM;
                        end
                    end else begin
                        cnt_prox = '0;
`ifdef BOTOES_PRIORIDADE_EN
                        estado_prox = OCIOSO;
`else
                        erro_prox   = 1'b1;
                        estado_prox = ESPERA_SOLTA;
`endif
                    end
                end

                ESPERA_SOLTA: begin
                    if (!amostra_zero) begin
                        cnt_prox = '0;
                    end else if (cnt == CNT_ULTIMO) begin
                        estado_prox = OCIOSO;
                        cnt_prox    = '0;
                    end else begin
                        cnt_prox = cnt + CNT_UM;
                    end
                end

                default: begin
                    estado_prox = OCIOSO;
                    cnt_prox    = '0;
                end
            endcase
        end
    end

    always_comb begin
        botoes_prox = '0;
        if ((estado_prox == PRESSIONADO) || (estado_prox == SOLTA)) begin
            botoes_prox = candidato_prox;
        end
    end

    // Outputs are registered from the next-state values so they change on the same edge as the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado        <= OCIOSO;
            cnt           <= '0;
            candidato     <= '0;
            botoes        <= '0;
            pressionado   <= 1'b0;
            erro_multiplo <= 1'b0;
        end else begin
            estado        <= estado_prox;
            cnt           <= cnt_prox;
            candidato     <= candidato_prox;
            botoes        <= botoes_prox;
            pressionado   <= |botoes_prox;
            erro_multiplo <= erro_prox;
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_botoes_condicionador.sv
// Directed bench for botoes_condicionador with DEBOUNCE_CYCLES=4 (press/release latency 7 edges).
module tb_botoes_condicionador;

    localparam int N = 7;

    logic         clock;
    logic         reset;
    logic         enable;
    logic [N-1:0] botoes_raw;
    logic [N-1:0] botoes;
    logic         pressionado;
    logic         erro_multiplo;
    logic [2:0]   db_estado;

    int compared   = 0;
    int mismatched = 0;

    botoes_condicionador #(
        .N_BOTOES(N),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .botoes_raw(botoes_raw),
        .botoes(botoes),
        .pressionado(pressionado),
        .erro_multiplo(erro_multiplo),
        .db_estado(db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change on the falling edge; the next rising edge counts as edge 1.
    task automatic applyStimulus(input logic [N-1:0] raw, input logic en);
        @(negedge clock);
        botoes_raw = raw;
        enable     = en;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        botoes_raw = '0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_botoes", 32'(botoes), 32'h0);
        checkOutput("reset_press", 32'(pressionado), 32'h0);
        checkOutput("reset_erro", 32'(erro_multiplo), 32'h0);
        checkOutput("reset_estado", 32'(db_estado), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        waitEdges(2);
        checkOutput("idle_botoes", 32'(botoes), 32'h0);

        // Clean press
        applyStimulus(7'b0000100, 1'b1);
        waitEdges(6);
        checkOutput("press_e6_botoes", 32'(botoes), 32'h0);
        checkOutput("press_e6_estado", 32'(db_estado), 32'h1);
        waitEdges(1);
        checkOutput("press_e7_botoes", 32'(botoes), 32'h04);
        checkOutput("press_e7_press", 32'(pressionado), 32'h1);
        checkOutput("press_e7_estado", 32'(db_estado), 32'h2);
        waitEdges(10);
        checkOutput("press_hold_botoes", 32'(botoes), 32'h04);

        // Release bounce: 2 cycles low then back high
        applyStimulus(7'b0000000, 1'b1);
        for (int i = 0; i < 2; i++) begin
            waitEdges(1);
            checkOutput("relbounce_low", 32'(botoes), 32'h04);
        end
        applyStimulus(7'b0000100, 1'b1);
        for (int i = 0; i < 8; i++) begin
            waitEdges(1);
            checkOutput("relbounce_back", 32'(botoes), 32'h04);
        end
        checkOutput("relbounce_estado", 32'(db_estado), 32'h2);

        // Sustained release
        applyStimulus(7'b0000000, 1'b1);
        waitEdges(6);
        checkOutput("rel_e6_botoes", 32'(botoes), 32'h04);
        checkOutput("rel_e6_estado", 32'(db_estado), 32'h3);
        waitEdges(1);
        checkOutput("rel_e7_botoes", 32'(botoes), 32'h0);
        checkOutput("rel_e7_press", 32'(pressionado), 32'h0);
        checkOutput("rel_e7_estado", 32'(db_estado), 32'h0);

        // Press bounce: 2 high / 2 low, four phases, then held high
        for (int k = 0; k < 4; k++) begin
            applyStimulus((k % 2 == 0) ? 7'b0000100 : 7'b0000000, 1'b1);
            waitEdges(1);
            checkOutput("pbounce_botoes", 32'(botoes), 32'h0);
            waitEdges(1);
            checkOutput("pbounce_botoes", 32'(botoes), 32'h0);
        end
        applyStimulus(7'b0000100, 1'b1);
        waitEdges(6);
        checkOutput("pbounce_e6_botoes", 32'(botoes), 32'h0);
        waitEdges(1);
        checkOutput("pbounce_e7_botoes", 32'(botoes), 32'h04);
        applyStimulus(7'b0000000, 1'b1);
        waitEdges(8);
        checkOutput("pbounce_rel_botoes", 32'(botoes), 32'h0);

        // Chord rejected
        applyStimulus(7'b0010010, 1'b1);
        waitEdges(2);
        checkOutput("chord_e2_erro", 32'(erro_multiplo), 32'h0);
        waitEdges(1);
        checkOutput("chord_e3_erro", 32'(erro_multiplo), 32'h1);
        checkOutput("chord_e3_botoes", 32'(botoes), 32'h0);
        checkOutput("chord_e3_estado", 32'(db_estado), 32'h4);
        waitEdges(1);
        checkOutput("chord_e4_erro", 32'(erro_multiplo), 32'h0);
        waitEdges(6);
        checkOutput("chord_held_estado", 32'(db_estado), 32'h4);
        checkOutput("chord_held_botoes", 32'(botoes), 32'h0);
        applyStimulus(7'b0000000, 1'b1);
        waitEdges(8);
        checkOutput("chord_rel_estado", 32'(db_estado), 32'h0);

        // Async reset mid-press, button still held afterwards
        applyStimulus(7'b1000000, 1'b1);
        waitEdges(7);
        checkOutput("rst_pre_botoes", 32'(botoes), 32'h40);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("rst_async_botoes", 32'(botoes), 32'h0);
        checkOutput("rst_async_estado", 32'(db_estado), 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        waitEdges(6);
        checkOutput("rst_after_e6", 32'(botoes), 32'h0);
        waitEdges(1);
        checkOutput("rst_after_e7", 32'(botoes), 32'h40);

        // Enable low while pressed: synchronous clear
        applyStimulus(7'b1000000, 1'b0);
        #1;
        checkOutput("en_low_same_cycle", 32'(botoes), 32'h40);
        waitEdges(1);
        checkOutput("en_low_botoes", 32'(botoes), 32'h0);
        checkOutput("en_low_estado", 32'(db_estado), 32'h0);
        checkOutput("en_low_erro", 32'(erro_multiplo), 32'h0);
        waitEdges(2);
        applyStimulus(7'b1000000, 1'b1);
        waitEdges(4);
        checkOutput("en_high_e4", 32'(botoes), 32'h0);
        waitEdges(3);
        checkOutput("en_high_e7", 32'(botoes), 32'h40);
        checkOutput("en_high_press", 32'(pressionado), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
